sample_readout: RTL and testbench



---
 rtl/sample_readout.sv | 167 ++++++++++++++++
 tb/tb_sample_readout.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_readout.sv
// rtl/sample_readout.sv - dumps the capture buffer as a framed byte stream in trigger-relative order.
// Optional READOUT_CHECKSUM_EN appends a mod-256 sum of header and sample bytes as the final byte.
module sample_readout #(
    parameter int          DATA_WIDTH     = 8,
    parameter int          ADDR_WIDTH     = 11,
    parameter int          PRE_TRIG_DEPTH = 1024,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] trigger_index,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_RD, S_LAT, S_SEND, S_FIN, S_TAIL
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] PRE_OFF  = ADDR_WIDTH'(PRE_TRIG_DEPTH);
    localparam logic [ADDR_WIDTH:0]   LAST_CNT = {1'b0, {ADDR_WIDTH{1'b1}}};

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] trig_q, trig_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [1:0]            hdr_idx_q, hdr_idx_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  hs;

    assign hs = tx_valid_q && tx_ready;

`ifdef READOUT_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;

    // Running sum includes the byte being accepted this cycle, so sum_d is the tail value.
    always_comb begin
        sum_d = sum_q;
        if (state_q == S_IDLE) begin
            sum_d = 8'h00;
        end else if (hs && (state_q == S_HDR || state_q == S_SEND)) begin
            sum_d = sum_q + tx_data_q;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        trig_d     = trig_q;
        cnt_d      = cnt_q;
        hdr_idx_d  = hdr_idx_q;
        rd_addr_d  = rd_addr_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_HDR;
                    trig_d     = trigger_index;
                    cnt_d      = '0;
                    hdr_idx_d  = '0;
                    tx_data_d  = SYNC_BYTE;
                    tx_valid_d = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            S_HDR: begin
                if (hs) begin
                    hdr_idx_d = hdr_idx_q + 1'b1;
                    case (hdr_idx_q)
                        2'd0:    tx_data_d = 8'(trig_q >> 8);
                        2'd1:    tx_data_d = 8'(trig_q);
                        default: begin
                            tx_valid_d = 1'b0;
                            rd_addr_d  = trig_q - PRE_OFF;
                            state_d    = S_RD;
                        end
                    endcase
                end
            end
            S_RD: state_d = S_LAT;
            S_LAT: begin
                tx_data_d  = 8'(rd_data);
                tx_valid_d = 1'b1;
                state_d    = S_SEND;
            end
            S_SEND: begin
                if (hs) begin
                    if (cnt_q == LAST_CNT) begin
`ifdef READOUT_CHECKSUM_EN
                        tx_data_d = sum_d;
                        state_d   = S_TAIL;
`else
                        tx_valid_d = 1'b0;
                        done_d     = 1'b1;
                        busy_d     = 1'b0;
                        state_d    = S_FIN;
`endif
                    end else begin
                        cnt_d      = cnt_q + 1'b1;
                        rd_addr_d  = rd_addr_q + 1'b1;
                        tx_valid_d = 1'b0;
                        state_d    = S_RD;
                    end
                end
            end
            S_TAIL: begin
                if (hs) begin
                    tx_valid_d = 1'b0;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= S_IDLE;
            trig_q     <= '0;
            cnt_q      <= '0;
            hdr_idx_q  <= '0;
            rd_addr_q  <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef READOUT_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            trig_q     <= trig_d;
            cnt_q      <= cnt_d;
            hdr_idx_q  <= hdr_idx_d;
            rd_addr_q  <= rd_addr_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef READOUT_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    assign rd_addr  = rd_addr_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_sample_readout.sv
// tb/tb_sample_readout.sv - randomized bench for sample_readout against a frame-level reference model.
module tb_sample_readout;
    localparam int AW  = 11;
    localparam int N   = 2048;
    localparam int PRE = 1024;
`ifdef READOUT_CHECKSUM_EN
    localparam int FLEN = N + 4;
`else
    localparam int FLEN = N + 3;
`endif

    logic          sys_clk = 1'b0;
    logic          sys_rst, start, tx_ready, tx_valid, busy, done;
    logic [AW-1:0] trigger_index, rd_addr;
    logic [7:0]    rd_data, tx_data;
    logic [7:0]    mem [N];

    sample_readout dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .trigger_index(trigger_index),
        .rd_addr(rd_addr), .rd_data(rd_data), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .done(done)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) rd_data <= mem[rd_addr];

    typedef struct {
        logic [7:0]    b;
        logic          is_s;
        logic [AW-1:0] a;
    } exp_t;

    exp_t          expq[$];
    logic [7:0]    cap_b[$];
    logic [AW-1:0] cap_a[$];
    logic [7:0]    basic_b[$];
    int compared = 0, mismatched = 0;
    int done_count = 0;
    int ready_pct = 100;
    int m_state = 0;  // 0 idle, 1 frame in progress, 2 done cycle
    logic          p_start, p_valid, p_ready, p_lastpop;
    logic [7:0]    p_data;
    logic [AW-1:0] p_trig;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Expected frame: header, then N samples starting PRE before the trigger, optional sum byte.
    task automatic build(input logic [AW-1:0] trig);
        int base;
        logic [7:0] s;
        exp_t e;
        base = (int'(trig) - PRE + N) % N;
        s = 8'h00;
        e.is_s = 1'b0;
        e.a = '0;
        e.b = 8'hA5;         expq.push_back(e); s += e.b;
        e.b = 8'(trig >> 8); expq.push_back(e); s += e.b;
        e.b = trig[7:0];     expq.push_back(e); s += e.b;
        for (int i = 0; i < N; i++) begin
            e.is_s = 1'b1;
            e.a = AW'((base + i) % N);
            e.b = mem[e.a];
            expq.push_back(e);
            s += e.b;
        end
`ifdef READOUT_CHECKSUM_EN
        e.is_s = 1'b0;
        e.b = s;
        expq.push_back(e);
`endif
    endtask

    always @(negedge sys_clk) begin
        if (sys_rst) begin
            chk("rst_rd_addr", 32'(rd_addr), 0);
            chk("rst_tx_data", 32'(tx_data), 0);
            chk("rst_tx_valid", 32'(tx_valid), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_done", 32'(done), 0);
            m_state = 0;
            expq.delete();
            p_start = 1'b0; p_valid = 1'b0; p_ready = 1'b0; p_lastpop = 1'b0;
            p_data = '0; p_trig = '0;
        end else begin
            case (m_state)
                0: if (p_start) begin
                    cap_b.delete();
                    cap_a.delete();
                    build(p_trig);
                    m_state = 1;
                end
                1: if (p_lastpop) m_state = 2;
                default: m_state = 0;
            endcase
            p_lastpop = 1'b0;
            chk("busy", 32'(busy), 32'(m_state == 1));
            chk("done", 32'(done), 32'(m_state == 2));
            if (m_state != 1) begin
                chk("valid_outside_frame", 32'(tx_valid), 0);
            end else begin
                if (p_valid && !p_ready) begin
                    chk("stall_valid", 32'(tx_valid), 1);
                    chk("stall_data", 32'(tx_data), 32'(p_data));
                end
                if (tx_valid && tx_ready) begin
                    chk("byte_expected", 32'(expq.size() != 0), 1);
                    if (expq.size() != 0) begin
                        exp_t e;
                        e = expq.pop_front();
                        chk("tx_byte", 32'(tx_data), 32'(e.b));
                        cap_b.push_back(tx_data);
                        if (e.is_s) begin
                            chk("sample_rd_addr", 32'(rd_addr), 32'(e.a));
                            cap_a.push_back(rd_addr);
                        end
                        if (expq.size() == 0) p_lastpop = 1'b1;
                    end
                end
            end
            if (done) done_count++;
            p_start = start; p_trig = trigger_index;
            p_valid = tx_valid; p_ready = tx_ready; p_data = tx_data;
        end
    end

    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge sys_clk);
            #1;
            tx_ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    task automatic pulse_start(input logic [AW-1:0] trig);
        @(posedge sys_clk); #1;
        start = 1'b1;
        trigger_index = trig;
        @(posedge sys_clk); #1;
        start = 1'b0;
        trigger_index = AW'($urandom);
    endtask

    task automatic wait_done(input int d0);
        for (int c = 0; c < 20000 && done_count == d0; c++) @(posedge sys_clk);
        repeat (5) @(posedge sys_clk);
        chk("done_pulses", 32'(done_count - d0), 1);
    endtask

    task automatic run_frame(input logic [AW-1:0] trig, input int pct);
        int d0;
        ready_pct = pct;
        d0 = done_count;
        pulse_start(trig);
        wait_done(d0);
        chk("frame_len", 32'(cap_b.size()), 32'(FLEN));
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
    endtask

    initial begin
        int d0, diffs;
        sys_rst = 1'b1;
        start = 1'b0;
        trigger_index = '0;
        for (int i = 0; i < N; i++) mem[i] = 8'(i);
        repeat (3) @(posedge sys_clk);
        #1 sys_rst = 1'b0;

        run_frame(11'h400, 100);
        if (cap_b.size() == FLEN) begin
            chk("basic_sync", 32'(cap_b[0]), 32'hA5);
            chk("basic_trig_hi", 32'(cap_b[1]), 32'h04);
            chk("basic_trig_lo", 32'(cap_b[2]), 32'h00);
            chk("basic_sample0", 32'(cap_b[3]), 32'h00);
            chk("basic_sample255", 32'(cap_b[3 + 255]), 32'hFF);
            chk("basic_trig_sample", 32'(cap_b[3 + 1024]), 32'h00);
`ifdef READOUT_CHECKSUM_EN
            chk("basic_checksum", 32'(cap_b[N + 3]), 32'hA9);
`endif
        end
        basic_b = cap_b;

        run_frame(11'h010, 100);
        if (cap_b.size() == FLEN && cap_a.size() == N) begin
            chk("wrap_sync", 32'(cap_b[0]), 32'hA5);
            chk("wrap_trig_hi", 32'(cap_b[1]), 32'h00);
            chk("wrap_trig_lo", 32'(cap_b[2]), 32'h10);
            chk("wrap_first_addr", 32'(cap_a[0]), 32'h410);
            chk("wrap_last_addr", 32'(cap_a[N - 1]), 32'h40F);
            chk("wrap_trig_addr", 32'(cap_a[1024]), 32'h010);
            chk("wrap_trig_sample", 32'(cap_b[3 + 1024]), 32'h10);
        end

        run_frame(11'h400, 30);
        diffs = 0;
        for (int i = 0; i < FLEN; i++)
            if (i >= cap_b.size() || i >= basic_b.size() || cap_b[i] !== basic_b[i]) diffs++;
        chk("backpressure_vs_basic", 32'(diffs), 0);

        randomize_mem();
        ready_pct = 70;
        d0 = done_count;
        pulse_start(AW'($urandom));
        repeat (600) @(posedge sys_clk);
        pulse_start(AW'($urandom));
        wait_done(d0);
        repeat (50) @(posedge sys_clk);
        chk("busy_start_single_done", 32'(done_count - d0), 1);
        chk("busy_start_idle", 32'(busy), 0);

        randomize_mem();
        ready_pct = 70;
        d0 = done_count;
        pulse_start(AW'($urandom));
        for (int c = 0; c < 20000 && cap_b.size() < 3 + 500; c++) @(posedge sys_clk);
        chk("reached_sample_500", 32'(cap_b.size() >= 3 + 500), 1);
        @(posedge sys_clk); #1 sys_rst = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        repeat (5) @(posedge sys_clk);
        chk("rst_no_done", 32'(done_count - d0), 0);
        run_frame(AW'($urandom), 70);

        randomize_mem();
        run_frame(11'h7FF, 60);
        randomize_mem();
        run_frame(AW'($urandom), 60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
